gp_cmd_reader: RTL and testbench

Graphics-processor front end that walks a command list in memory, the list the MIPS software builds in its GP command buffer. Software writes the list base address to the GP MMIO command register and pulses start. The block reads words over a simple pipelined word-read port (one-cycle read latency, like the instruction ROMs). It decodes FILL and LINE commands and hands them to the drawing engine over a valid/ready interface. It stops at a STOP word, on a bad opcode, or on the runaway limit.

---
 rtl/gp_pkg.sv | 39 +++
 rtl/gp_cmd_decode.sv | 32 +++
 rtl/gp_cmd_reader.sv | 157 +++++++++++++++
 tb/tb_gp_cmd_reader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_pkg.sv
// Shared GP command-list definitions: opcodes, header layout, reader states, command record.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package gp_pkg;

    // Header opcode values, found in header bits [31:24]
    localparam logic [7:0] OP_STOP = 8'h00;
    localparam logic [7:0] OP_FILL = 8'h01;
    localparam logic [7:0] OP_LINE = 8'h02;

    // Header field positions
    localparam int HDR_OP_MSB    = 31;
    localparam int HDR_OP_LSB    = 24;
    localparam int HDR_COLOR_MSB = 23;

    // Opcode encoding as seen by the drawing engine
    localparam logic [1:0] CMD_FILL = 2'd1;
    localparam logic [1:0] CMD_LINE = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_HDR,
        ST_WAIT_HDR,
        ST_REQ_ARG,
        ST_WAIT_ARG,
        ST_ISSUE
    } gp_state_t;

    // Command record handed to the drawing engine
    typedef struct packed {
        logic [1:0]  op;
        logic [23:0] color;
        logic [15:0] x0;
        logic [15:0] y0;
        logic [15:0] x1;
        logic [15:0] y1;
    } gp_cmd_t;

endpackage

// File: rtl/gp_cmd_decode.sv
// Classifies a command header opcode: STOP, legal/illegal, number of argument words.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: opcode = header bits [31:24]; is_stop/legal/nargs describe that opcode.
module gp_cmd_decode
    import gp_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       is_stop,
    output logic       legal,
    output logic [1:0] nargs
);

    always_comb begin
        is_stop = 1'b0;
        legal   = 1'b0;
        nargs   = 2'd0;
        case (opcode)
            OP_STOP: begin
                is_stop = 1'b1;
                legal   = 1'b1;
            end
            OP_FILL: legal = 1'b1;
            OP_LINE: begin
                legal = 1'b1;
                nargs = 2'd2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gp_cmd_reader.sv
// Walks a GP command list in memory, decodes FILL/LINE and issues them to the drawing engine.
// Latency: start -> first mem_req 1 cycle; FILL header grant -> cmd_valid 2 cycles.
// Backpressure: one read outstanding at most; fetching stalls while a command waits for cmd_ready.
// Ports: start/base_addr from MMIO; mem_req/mem_addr/mem_gnt/mem_rdata word-read port (1-cycle
//        read latency); cmd_* valid/ready command output; busy, sticky done and error status.
module gp_cmd_reader
    import gp_pkg::*;
#(
    parameter int MAX_WORDS = 4096,
    parameter int ADDR_W    = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       base_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [31:0]       mem_rdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_op,
    output logic [23:0]       cmd_color,
    output logic [15:0]       cmd_x0,
    output logic [15:0]       cmd_y0,
    output logic [15:0]       cmd_x1,
    output logic [15:0]       cmd_y1,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    gp_state_t         state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  count;
    logic              arg_idx;
    logic              done_q;
    logic              error_q;
    gp_cmd_t           cmd_q;

    logic              dec_stop;
    logic              dec_legal;
    logic [1:0]        dec_nargs;
    logic              in_req;
    logic              at_limit;
    logic              unused_addr_bits;

    // Byte-offset bits of the list base carry no meaning for a word list
    assign unused_addr_bits = ^base_addr[1:0];

    gp_cmd_decode u_decode (
        .opcode  (mem_rdata[HDR_OP_MSB:HDR_OP_LSB]),
        .is_stop (dec_stop),
        .legal   (dec_legal),
        .nargs   (dec_nargs)
    );

    assign in_req   = (state == ST_REQ_HDR) || (state == ST_REQ_ARG);
    // Runaway guard: once the word budget is spent the request is never raised
    assign at_limit = (count == CNT_W'(MAX_WORDS));

    assign mem_req   = in_req && !at_limit;
    assign mem_addr  = ptr;
    assign cmd_valid = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign cmd_op    = cmd_q.op;
    assign cmd_color = cmd_q.color;
    assign cmd_x0    = cmd_q.x0;
    assign cmd_y0    = cmd_q.y0;
    assign cmd_x1    = cmd_q.x1;
    assign cmd_y1    = cmd_q.y1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            count   <= '0;
            arg_idx <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ptr     <= ADDR_W'(base_addr[31:2]);
                        count   <= '0;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        state   <= ST_REQ_HDR;
                    end
                end

                ST_REQ_HDR, ST_REQ_ARG: begin
                    if (at_limit) begin
                        error_q <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (mem_gnt) begin
                        ptr   <= ptr + ADDR_W'(1);
                        count <= count + CNT_W'(1);
                        state <= (state == ST_REQ_HDR) ? ST_WAIT_HDR : ST_WAIT_ARG;
                    end
                end

                ST_WAIT_HDR: begin
                    if (!dec_legal) begin
                        error_q <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (dec_stop) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        cmd_q.color <= mem_rdata[HDR_COLOR_MSB:0];
                        cmd_q.x0    <= '0;
                        cmd_q.y0    <= '0;
                        cmd_q.x1    <= '0;
                        cmd_q.y1    <= '0;
                        if (dec_nargs == 2'd0) begin
                            cmd_q.op <= CMD_FILL;
                            state    <= ST_ISSUE;
                        end else begin
                            cmd_q.op <= CMD_LINE;
                            arg_idx  <= 1'b0;
                            state    <= ST_REQ_ARG;
                        end
                    end
                end

                ST_WAIT_ARG: begin
                    if (!arg_idx) begin
                        cmd_q.x0 <= mem_rdata[31:16];
                        cmd_q.y0 <= mem_rdata[15:0];
                        arg_idx  <= 1'b1;
                        state    <= ST_REQ_ARG;
                    end else begin
                        cmd_q.x1 <= mem_rdata[31:16];
                        cmd_q.y1 <= mem_rdata[15:0];
                        state    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (cmd_ready) begin
                        state <= ST_REQ_HDR;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gp_cmd_reader.sv
// Self-checking bench for gp_cmd_reader: list-walking reference model feeds a scoreboard.
// Latency: n/a.
// Backpressure: randomized mem_gnt and cmd_ready, plus a forced cmd_ready stall.
module tb_gp_cmd_reader;
    import gp_pkg::*;

    localparam int MAXW = 8;
    localparam int AW   = 30;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [31:0]   base_addr;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic [31:0]   mem_rdata;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [23:0]   cmd_color;
    logic [15:0]   cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic          busy, done, error;

    gp_cmd_reader #(.MAX_WORDS(MAXW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_color(cmd_color),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .busy(busy), .done(done), .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [31:0]   mem [logic [29:0]];
    logic [29:0]   exp_addr [$];
    gp_cmd_t       exp_cmd [$];
    int            stall_log [$];
    logic          exp_done, exp_err;
    int            exp_grants;
    int            grants = 0;
    int            gnt_pct = 100;
    int            ready_pct = 100;
    int            hold_cnt = 0;
    int            lat;
    gp_cmd_t       cur;

    assign cur = {cmd_op, cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] rd(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Reference: walk the list by the command-list rules and record every
    // word address fetched and every command that must come out.
    task automatic model(input logic [31:0] b);
        logic [29:0] p;
        logic [31:0] w;
        gp_cmd_t     c;
        int          cnt;
        bit          fin;
        p = b[31:2]; cnt = 0; fin = 0;
        exp_done = 0; exp_err = 0;
        while (!fin) begin
            if (cnt == MAXW) begin exp_err = 1; break; end
            exp_addr.push_back(p); w = rd(p); p = p + 30'd1; cnt++;
            case (w[31:24])
                8'h00: begin exp_done = 1; fin = 1; end
                8'h01: begin
                    c = '0; c.op = 2'd1; c.color = w[23:0];
                    exp_cmd.push_back(c);
                end
                8'h02: begin
                    c = '0; c.op = 2'd2; c.color = w[23:0];
                    for (int a = 0; a < 2; a++) begin
                        if (cnt == MAXW) begin exp_err = 1; fin = 1; break; end
                        exp_addr.push_back(p); w = rd(p); p = p + 30'd1; cnt++;
                        if (a == 0) {c.x0, c.y0} = w; else {c.x1, c.y1} = w;
                    end
                    if (!fin) exp_cmd.push_back(c);
                end
                default: begin exp_err = 1; fin = 1; end
            endcase
        end
        exp_grants = cnt;
    endtask

    // Memory and drawing-engine side: one-cycle read port plus cmd_ready driver
    logic        gnt_prev = 0;
    logic [29:0] addr_prev = '0;
    initial begin : env
        logic [29:0] ea;
        mem_gnt = 0; mem_rdata = '0; cmd_ready = 0;
        forever begin
            @(negedge clk);
            mem_rdata = gnt_prev ? rd(addr_prev) : $urandom;
            gnt_prev  = 0;
            mem_gnt   = ($urandom_range(1, 100) <= gnt_pct);
            if (rst_n && mem_req && mem_gnt) begin
                gnt_prev  = 1;
                addr_prev = mem_addr;
                grants++;
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fetch: addr %0h with none expected", mem_addr);
                end else begin
                    ea = exp_addr.pop_front();
                    chk("mem_addr", mem_addr, ea);
                end
            end
            if (rst_n && cmd_valid) chk("no_fetch_while_issuing", mem_req, 0);
            if (hold_cnt > 0) begin
                cmd_ready = 0;
                if (cmd_valid) hold_cnt--;
            end else begin
                cmd_ready = ($urandom_range(1, 100) <= ready_pct);
            end
        end
    end

    // Scoreboard monitor: compares every transfer and checks stability while stalled
    initial begin : monitor
        gp_cmd_t ec;
        gp_cmd_t prev_cmd = '0;
        bit      prev_stall = 0;
        int      stall_run = 0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                prev_stall = 0; stall_run = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid_held", cmd_valid, 1);
                    chk("stall_cmd_stable", cur, prev_cmd);
                end
                if (cmd_valid && cmd_ready) begin
                    if (exp_cmd.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_cmd: got %0h with none expected", cur);
                    end else begin
                        ec = exp_cmd.pop_front();
                        chk("cmd", cur, ec);
                    end
                    stall_log.push_back(stall_run);
                    stall_run = 0; prev_stall = 0;
                end else if (cmd_valid) begin
                    prev_stall = 1; prev_cmd = cur; stall_run++;
                end else begin
                    prev_stall = 0;
                end
            end
        end
    end

    // Start a list, optionally poke start again while busy, wait for idle, check status
    task automatic run_list(input logic [31:0] b, input int poke_at);
        int cycles;
        model(b);
        grants = 0;
        lat = -1;
        @(negedge clk); base_addr = b; start = 1;
        @(negedge clk); start = 0;
        #3;
        chk("start_mem_req", mem_req, 1);
        chk("start_busy", busy, 1);
        chk("start_clears_done", done, 0);
        chk("start_clears_error", error, 0);
        cycles = 1;
        while (busy && cycles < 400) begin
            @(negedge clk); #3;
            cycles++;
            if (start) start = 0;
            if (cmd_valid && lat < 0) lat = cycles;
            if (cycles == poke_at) begin
                chk("poke_while_busy", busy, 1);
                base_addr = 32'h0000_0100; start = 1;
            end
        end
        start = 0;
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", busy, cycles);
        end
        chk("end_done", done, exp_done);
        chk("end_error", error, exp_err);
        chk("end_grants", grants, exp_grants);
        chk("cmds_outstanding", exp_cmd.size(), 0);
        chk("fetches_outstanding", exp_addr.size(), 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : main
        logic [31:0] b;
        logic [29:0] wa;
        int          r;
        rst_n = 0; start = 0; base_addr = '0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cmd", cur, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // FILL list
        mem.delete();
        mem[30'h0410_0000] = 32'h01FF_FFFF;
        mem[30'h0410_0001] = 32'h0000_0000;
        run_list(32'h1040_0000, -1);
        chk("fill_latency", lat, 3);

        // LINE list
        mem.delete();
        mem[30'h0420_0000] = 32'h02FF_0000;
        mem[30'h0420_0001] = 32'h00D2_0140;
        mem[30'h0420_0002] = 32'h0042_00B4;
        mem[30'h0420_0003] = 32'h0000_0000;
        run_list(32'h1080_0000, -1);

        // Backpressure: first command held off for 10 cycles
        mem.delete();
        mem[30'h0000_0400] = 32'h0112_3456;
        mem[30'h0000_0401] = 32'h01AB_CDEF;
        stall_log.delete();
        hold_cnt = 10;
        run_list(32'h0000_1000, -1);
        chk("stall_cycles", (stall_log.size() > 0) ? stall_log[0] : -1, 10);

        // Illegal opcode, then a new start clears error
        mem.delete();
        mem[30'h0000_0800] = 32'h0700_0000;
        run_list(32'h0000_2000, -1);
        mem[30'h0000_0810] = 32'h0100_0001;
        run_list(32'h0000_2040, -1);

        // Runaway: every word is a FILL, plus an ignored start while busy
        mem.delete();
        for (int i = 0; i < 16; i++) mem[30'h0000_0C00 + 30'(i)] = 32'h0100_0000;
        run_list(32'h0000_3000, 5);
        chk("runaway_grants", grants, MAXW);

        // Reset while waiting for the first LINE argument
        mem.delete();
        mem[30'h0000_1000] = 32'h0200_00AA;
        mem[30'h0000_1001] = 32'h1111_2222;
        mem[30'h0000_1002] = 32'h3333_4444;
        model(32'h0000_4000);
        grants = 0;
        @(negedge clk); base_addr = 32'h0000_4000; start = 1;
        @(negedge clk); start = 0;
        r = 0;
        while (grants < 2 && r < 50) begin @(negedge clk); #4; r++; end
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_cmd_valid", cmd_valid, 0);
        chk("midrst_cmd", cur, 0);
        exp_cmd.delete(); exp_addr.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        #3;
        chk("postrst_idle", busy, 0);
        chk("postrst_no_req", mem_req, 0);
        chk("postrst_no_cmd", cmd_valid, 0);
        chk("postrst_grants", grants, 2);
        mem[30'h0000_1010] = 32'h0155_5555;
        run_list(32'h0000_4040, -1);

        // Randomized lists, including one that wraps the word address
        for (int t = 0; t < 24; t++) begin
            mem.delete();
            b = (t == 0) ? 32'hFFFF_FFF8 : $urandom;
            wa = b[31:2];
            for (int i = 0; i < 10; i++) begin
                r = $urandom_range(0, 99);
                if (r < 35)      mem[wa + 30'(i)] = {8'h01, 24'($urandom)};
                else if (r < 65) mem[wa + 30'(i)] = {8'h02, 24'($urandom)};
                else if (r < 72) mem[wa + 30'(i)] = 32'h0000_0000;
                else if (r < 77) mem[wa + 30'(i)] = {8'($urandom_range(3, 255)), 24'($urandom)};
                else             mem[wa + 30'(i)] = $urandom;
            end
            gnt_pct   = $urandom_range(40, 100);
            ready_pct = $urandom_range(30, 100);
            run_list(b, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
